// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between NREQ requesters.
// Each operation takes one execute cycle and returns its result on a valid/ready response.
module alu_sched #(
    parameter int W     = 8,
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [3*NREQ-1:0]  req_op,
    input  logic [W*NREQ-1:0]  req_a,
    input  logic [W*NREQ-1:0]  req_b,
    output logic [2:0]         alu_op,
    output logic [W-1:0]       alu_a,
    output logic [W-1:0]       alu_b,
    input  logic [W-1:0]       alu_result,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [CNT_W-1:0]   op_count
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg, gid_reg, win;
    logic [PTR_W:0]     cand;
    logic               any_valid;
    logic [2:0]         op_reg;
    logic [W-1:0]       a_reg, b_reg;
    logic [W-1:0]       rsp_data_reg;
    logic               rsp_zero_reg, rsp_err_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               accept, done;

    // Search starts just past the last served requester, wrapping modulo NREQ.
    always_comb begin
        win       = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NREQ))
                cand = cand - (PTR_W+1)'(NREQ);
            if (!any_valid && req_valid[cand[PTR_W-1:0]]) begin
                any_valid = 1'b1;
                win       = cand[PTR_W-1:0];
            end
        end
    end

    assign accept = (state_reg == IDLE) && any_valid;
    assign done   = (state_reg == RESP) && rsp_ready[gid_reg];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_hs
            // Gated by Reset_n so no grant is offered while reset is held.
            assign req_ready[gi] = Reset_n && accept && (win == PTR_W'(gi));
            assign rsp_valid[gi] = (state_reg == RESP) && (gid_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        alu_op = OP_CLR;
        alu_a  = '0;
        alu_b  = '0;
        if (state_reg == EXEC && op_reg != OP_ILL) begin
            alu_op = op_reg;
            alu_a  = a_reg;
            alu_b  = b_reg;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= PTR_W'(NREQ-1);
            gid_reg      <= '0;
            op_reg       <= OP_CLR;
            a_reg        <= '0;
            b_reg        <= '0;
            rsp_data_reg <= '0;
            rsp_zero_reg <= 1'b0;
            rsp_err_reg  <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg  <= req_op[3*int'(win) +: 3];
                a_reg   <= req_a[W*int'(win) +: W];
                b_reg   <= req_b[W*int'(win) +: W];
                gid_reg <= win;
            end
            if (state_reg == EXEC) begin
                if (op_reg == OP_ILL) begin
                    rsp_data_reg <= '0;
                    rsp_zero_reg <= 1'b1;
                    rsp_err_reg  <= 1'b1;
                end else begin
                    rsp_data_reg <= alu_result;
                    rsp_zero_reg <= (alu_result == '0);
                    rsp_err_reg  <= 1'b0;
                end
            end
            if (done) begin
                ptr_reg   <= gid_reg;
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_zero = rsp_zero_reg;
    assign rsp_err  = rsp_err_reg;
    assign op_count = count_reg;

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: transaction-level model checked every cycle, plus directed scenarios.
module tb_alu_sched;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [5:0]  req_op;
    logic [15:0] req_a, req_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_result, rsp_data;
    logic        rsp_zero, rsp_err;
    logic [3:0]  op_count;

    alu_sched #(.W(8), .NREQ(2), .CNT_W(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a << b;
            3'd2:    return a >> b;
            3'd3:    return a ^ b;
            3'd4:    return a & b;
            3'd5:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding op, age counts cycles since grant.
    bit         m_busy;
    int         m_age, m_owner, m_ptr, m_cnt;
    logic [2:0] m_op;
    logic [7:0] m_a, m_b, m_data;
    bit         m_dz, m_de;

    function automatic int rr_pick(input int p, input logic [1:0] v);
        for (int k = 1; k <= 2; k++) begin
            int i;
            i = (p + k) % 2;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_owner = 0; m_ptr = 1; m_cnt = 0;
        m_data = 8'h00; m_dz = 0; m_de = 0;
    endtask

    initial begin
        int w;
        int e_rr, e_rv, e_op, e_a, e_b;
        model_reset();
        forever begin
            @(negedge Clk);
            if (!Reset_n) model_reset();
            e_rr = 0; e_rv = 0; e_op = 6; e_a = 0; e_b = 0;
            if (Reset_n && !m_busy) begin
                w = rr_pick(m_ptr, req_valid);
                if (w >= 0) e_rr = 1 << w;
            end
            if (m_busy && m_age == 0 && m_op != 3'd7) begin
                e_op = int'(m_op); e_a = int'(m_a); e_b = int'(m_b);
            end
            if (m_busy && m_age >= 1) e_rv = 1 << m_owner;
            chk("req_ready", int'(req_ready), e_rr);
            chk("rsp_valid", int'(rsp_valid), e_rv);
            chk("alu_op", int'(alu_op), e_op);
            chk("alu_a", int'(alu_a), e_a);
            chk("alu_b", int'(alu_b), e_b);
            chk("rsp_data", int'(rsp_data), int'(m_data));
            chk("rsp_zero", int'(rsp_zero), int'(m_dz));
            chk("rsp_err", int'(rsp_err), int'(m_de));
            chk("op_count", int'(op_count), m_cnt);
            @(posedge Clk);
            if (Reset_n) begin
                if (!m_busy) begin
                    w = rr_pick(m_ptr, req_valid);
                    if (w >= 0) begin
                        m_busy = 1; m_age = 0; m_owner = w;
                        m_op = req_op[3*w +: 3]; m_a = req_a[8*w +: 8]; m_b = req_b[8*w +: 8];
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                    m_de = (m_op == 3'd7);
                    m_data = m_de ? 8'h00 : alu_f(m_op, m_a, m_b);
                    m_dz = (m_data == 8'h00);
                end else if (rsp_ready[m_owner]) begin
                    m_busy = 0; m_ptr = m_owner; m_cnt = (m_cnt + 1) % 16;
                end
            end
        end
    end

    // Values sampled just before each active edge by step().
    logic [1:0] acc_s, rr_s, rv_s;
    logic [7:0] rd_s;
    logic       rz_s, re_s;
    logic [2:0] op_s;
    logic [7:0] a_s;

    task automatic step();
        @(negedge Clk);
        acc_s = req_valid & req_ready;
        rr_s = req_ready; rv_s = rsp_valid; rd_s = rsp_data;
        rz_s = rsp_zero; re_s = rsp_err; op_s = alu_op; a_s = alu_a;
        @(posedge Clk);
        #1;
        req_valid = req_valid & ~acc_s;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[i] = 1'b1;
        req_op[3*i +: 3] = op;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
        int grants[4];
        int ngr, ndone, prev;
        bit seen;
        Reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        req_op = 6'd0; req_a = 16'd0; req_b = 16'd0;

        // Single ADD from requester 0
        do_reset();
        chk("t1_reset_count", int'(op_count), 0);
        set_req(0, 3'd0, 8'h05, 8'h03); rsp_ready = 2'b11;
        step(); chk("t1_req_ready", int'(rr_s), 1);
        step(); chk("t1_alu_op", int'(op_s), 0); chk("t1_alu_a", int'(a_s), 5);
        step(); chk("t1_rsp_valid", int'(rv_s), 1); chk("t1_rsp_data", int'(rd_s), 8);
        chk("t1_count", int'(op_count), 1);
        $display("t1 single ADD done checks=%0d", checks);

        // Both requesters continuously valid
        do_reset();
        rsp_ready = 2'b11; ngr = 0;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            set_req(0, 3'd5, 8'h09, 8'h09);
            set_req(1, 3'd3, 8'hF0, 8'h0F);
            step();
            if (acc_s != 2'b00) begin
                grants[ngr] = (acc_s == 2'b01) ? 0 : 1;
                ngr++;
            end
            if (rv_s == 2'b01) begin
                chk("t2_req0_data", int'(rd_s), 0); chk("t2_req0_zero", int'(rz_s), 1);
            end
            if (rv_s == 2'b10) begin
                chk("t2_req1_data", int'(rd_s), 8'hFF); chk("t2_req1_zero", int'(rz_s), 0);
            end
        end
        chk("t2_grant_count", ngr, 4);
        for (int g = 0; g < 4; g++) chk("t2_grant_order", (g < ngr) ? grants[g] : -1, g % 2);
        req_valid = 2'b00;
        repeat (4) step();
        $display("t2 round-robin done checks=%0d", checks);

        // Backpressure on an LSH response
        do_reset();
        set_req(0, 3'd1, 8'h81, 8'h01); set_req(1, 3'd0, 8'h01, 8'h01); rsp_ready = 2'b00;
        step(); chk("t3_grant", int'(acc_s), 1);
        step();
        repeat (5) begin
            step();
            chk("t3_rsp_valid", int'(rv_s), 1); chk("t3_rsp_data", int'(rd_s), 2);
            chk("t3_no_ready", int'(rr_s), 0);
        end
        chk("t3_count_held", int'(op_count), 0);
        rsp_ready = 2'b01;
        step(); chk("t3_count_accept", int'(op_count), 1);
        rsp_ready = 2'b11;
        repeat (5) step();
        $display("t3 backpressure done checks=%0d", checks);

        // Illegal op
        do_reset();
        set_req(0, 3'd7, 8'h12, 8'h34); rsp_ready = 2'b01;
        step(); chk("t4_alu_idle", int'(op_s), 6);
        step(); chk("t4_alu_exec", int'(op_s), 6);
        step(); chk("t4_rsp_valid", int'(rv_s), 1); chk("t4_rsp_data", int'(rd_s), 0);
        chk("t4_rsp_err", int'(re_s), 1); chk("t4_rsp_zero", int'(rz_s), 1);
        chk("t4_count", int'(op_count), 1);
        $display("t4 illegal op done checks=%0d", checks);

        // Reset during EXEC
        do_reset();
        set_req(1, 3'd0, 8'h03, 8'h04); rsp_ready = 2'b11;
        step(); chk("t5_grant1", int'(acc_s), 2);
        Reset_n = 1'b0;
        #1;
        chk("t5_rst_alu_op", int'(alu_op), 6); chk("t5_rst_rsp_valid", int'(rsp_valid), 0);
        chk("t5_rst_req_ready", int'(req_ready), 0); chk("t5_rst_count", int'(op_count), 0);
        repeat (2) @(posedge Clk);
        #1;
        set_req(0, 3'd4, 8'h3C, 8'h0F); set_req(1, 3'd0, 8'h03, 8'h04);
        Reset_n = 1'b1;
        step(); chk("t5_first_winner", int'(acc_s), 1);
        repeat (8) step();
        $display("t5 reset mid-op done checks=%0d", checks);

        // Counter wrap with a 4-bit counter
        do_reset();
        rsp_ready = 2'b11; ndone = 0; prev = 0; seen = 0;
        for (int c = 0; c < 200 && ndone < 17; c++) begin
            if (!req_valid[0]) set_req(0, 3'($urandom_range(0, 5)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 7)));
            step();
            if (rv_s[0]) ndone++;
            if (prev == 15 && op_count == 4'd0) seen = 1;
            prev = int'(op_count);
        end
        chk("t6_done", ndone, 17); chk("t6_count", int'(op_count), 1); chk("t6_wrap_seen", int'(seen), 1);
        $display("t6 counter wrap done checks=%0d", checks);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            for (int i = 0; i < 2; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            rsp_ready = 2'($urandom_range(0, 3));
            step();
        end
        $display("t7 random traffic done checks=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
